// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package disp_pkg;

    typedef enum logic [1:0] {
        StOff,
        StGuard,
        StShow
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, entry 15 (F) first down to entry 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decode with blank override.
module seg7_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Four-digit (parameterisable) display scanner: scan_clk is synchronised as data, each rising
// edge advances one digit, with an all-off guard interval and per-scan shadowing of the inputs.
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_clk,
    input  logic                      enable,
    input  logic [4*DIGITS-1:0]       value,
    input  logic [DIGITS-1:0]         dp,
    input  logic                      blank_lz,
    output logic [DIGITS-1:0]         an,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic [$clog2(DIGITS)-1:0] digit_idx
);

    localparam int IdxW = $clog2(DIGITS);
    localparam int CntW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = (BLANK_CYCLES > 0) ? CntW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
    localparam disp_state_e     EnterSt = (BLANK_CYCLES == 0) ? StShow : StGuard;

    logic                s1_q, s2_q, s3_q;
    logic                scan_rise;
    disp_state_e         state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                latch;
    logic [4*DIGITS-1:0] val_sh_q, val_sh_d;
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic                blz_sh_q, blz_sh_d;
    logic [DIGITS-1:0]   lz_blank;
    logic                show_d;
    logic [3:0]          nibble_d;
    logic                seg_blank_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_n_q, dp_n_d;

    assign scan_rise = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        latch   = 1'b0;
        if (!enable) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (scan_rise) begin
                        state_d = EnterSt;
                        cnt_d   = CntLoad;
                        idx_d   = '0;
                        latch   = 1'b1;
                    end
                end
                StGuard: begin
                    // Edges arriving here are intentionally dropped.
                    if (cnt_q == '0) begin
                        state_d = StShow;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StShow: begin
                    if (scan_rise) begin
                        state_d = EnterSt;
                        cnt_d   = CntLoad;
                        if (idx_q == LastIdx) begin
                            idx_d = '0;
                            latch = 1'b1;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    always_comb begin
        val_sh_d = val_sh_q;
        dp_sh_d  = dp_sh_q;
        blz_sh_d = blz_sh_q;
        if (latch) begin
            val_sh_d = value;
            dp_sh_d  = dp;
            blz_sh_d = blank_lz;
        end
    end

    // Digit k is blank when it and every higher nibble are zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = blz_sh_d;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run & (val_sh_d[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end

    // Outputs are computed from next-state values so an/seg/dp_n move with the state register.
    always_comb begin
        show_d      = (state_d == StShow);
        nibble_d    = val_sh_d[{idx_d, 2'b00} +: 4];
        seg_blank_d = ~show_d | lz_blank[idx_d];
        an_d        = '1;
        dp_n_d      = 1'b1;
        if (show_d) begin
            an_d   = ~(DIGITS'(1) << idx_d);
            dp_n_d = ~dp_sh_d[idx_d];
        end
    end

    seg7_hex_decode u_decode (
        .nibble_i (nibble_d),
        .blank_i  (seg_blank_d),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= StOff;
            cnt_q    <= '0;
            idx_q    <= '0;
            val_sh_q <= '0;
            dp_sh_q  <= '0;
            blz_sh_q <= 1'b0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_n_q   <= 1'b1;
        end else begin
            s1_q     <= scan_clk;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            val_sh_q <= val_sh_d;
            dp_sh_q  <= dp_sh_d;
            blz_sh_q <= blz_sh_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_n_q   <= dp_n_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed-vector bench for disp_scan with DIGITS = 4 and a 4-cycle guard interval.
module tb_disp_scan;

    localparam int DIGITS = 4;
    localparam int BLANK  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                scan_clk;
    logic                enable;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                blank_lz;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp_n;
    logic [1:0]          digit_idx;

    int vectors     = 0;
    int miscompares = 0;

    disp_scan #(
        .DIGITS       (DIGITS),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_clk  (scan_clk),
        .enable    (enable),
        .value     (value),
        .dp        (dp),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp_n      (dp_n),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One rising scan edge, then enough low time to finish the guard and re-arm the sync chain.
    task automatic advance;
        scan_clk = 1'b1;
        repeat (3) tick();
        scan_clk = 1'b0;
        repeat (BLANK + 2) tick();
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        scan_clk = 1'b0;
        enable   = 1'b1;
        value    = 16'h1234;
        dp       = 4'b0000;
        blank_lz = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        vectors++;
        if (an !== 4'b1111) begin
            miscompares++; $display("FAIL reset_an: got %b want 1111", an);
        end
        vectors++;
        if (seg !== 7'h7F) begin
            miscompares++; $display("FAIL reset_seg: got %h want 7f", seg);
        end
        vectors++;
        if (dp_n !== 1'b1 || digit_idx !== 2'd0) begin
            miscompares++; $display("FAIL reset_dp_idx: got %b/%0d want 1/0", dp_n, digit_idx);
        end
        repeat (8) tick();
        vectors++;
        if (an !== 4'b1111) begin
            miscompares++; $display("FAIL off_no_edge: got %b want 1111", an);
        end
    endtask

    task automatic test_scan;
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        int         guard_cnt;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int i = 0; i < 8; i++) begin
            scan_clk = 1'b1;
            repeat (3) tick();
            scan_clk  = 1'b0;
            guard_cnt = 0;
            while (an === 4'b1111 && guard_cnt < 20) begin
                guard_cnt++;
                tick();
            end
            vectors++;
            if (guard_cnt !== BLANK) begin
                miscompares++; $display("FAIL guard_len[%0d]: got %0d want %0d", i, guard_cnt, BLANK);
            end
            vectors++;
            if (an !== exp_an[i%4] || seg !== exp_seg[i%4]) begin
                miscompares++;
                $display("FAIL scan[%0d]: got an=%b seg=%h want an=%b seg=%h",
                         i, an, seg, exp_an[i%4], exp_seg[i%4]);
            end
            vectors++;
            if (digit_idx !== 2'(i % 4) || dp_n !== 1'b1) begin
                miscompares++;
                $display("FAIL scan_idx[%0d]: got %0d/%b want %0d/1", i, digit_idx, dp_n, i % 4);
            end
            repeat (5) tick();
        end
    endtask

    task automatic test_edge_latency;
        scan_clk = 1'b1;
        tick();
        tick();
        vectors++;
        if (digit_idx !== 2'd3 || an !== 4'b0111) begin
            miscompares++; $display("FAIL lat_n2: got %0d/%b want 3/0111", digit_idx, an);
        end
        tick();
        vectors++;
        if (digit_idx !== 2'd0 || an !== 4'b1111) begin
            miscompares++; $display("FAIL lat_n3: got %0d/%b want 0/1111", digit_idx, an);
        end
        scan_clk = 1'b0;
        repeat (10) tick();
        vectors++;
        if (digit_idx !== 2'd0 || an !== 4'b1110) begin
            miscompares++; $display("FAIL fall_ignored: got %0d/%b want 0/1110", digit_idx, an);
        end
    endtask

    task automatic test_lz;
        logic [6:0] exp_lz [4];
        logic [6:0] exp_nl [4];
        logic [3:0] exp_dpn;
        exp_lz  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        exp_nl  = '{7'h40, 7'h12, 7'h40, 7'h40};
        exp_dpn = 4'b1011;
        value    = 16'h0050;
        blank_lz = 1'b1;
        dp       = 4'b0100;
        repeat (3) advance();
        for (int k = 0; k < 4; k++) begin
            advance();
            vectors++;
            if (seg !== exp_lz[k] || dp_n !== exp_dpn[k]) begin
                miscompares++;
                $display("FAIL lz_on[%0d]: got seg=%h dp_n=%b want seg=%h dp_n=%b",
                         k, seg, dp_n, exp_lz[k], exp_dpn[k]);
            end
        end
        blank_lz = 1'b0;
        dp       = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            advance();
            vectors++;
            if (seg !== exp_nl[k]) begin
                miscompares++; $display("FAIL lz_off[%0d]: got %h want %h", k, seg, exp_nl[k]);
            end
        end
    endtask

    task automatic test_no_tear;
        value = 16'h1111;
        advance();
        vectors++;
        if (seg !== 7'h79 || an !== 4'b1110) begin
            miscompares++; $display("FAIL tear_d0: got %h/%b want 79/1110", seg, an);
        end
        advance();
        advance();
        value = 16'h2222;
        advance();
        vectors++;
        if (seg !== 7'h79 || an !== 4'b0111) begin
            miscompares++; $display("FAIL tear_d3: got %h/%b want 79/0111", seg, an);
        end
        advance();
        vectors++;
        if (seg !== 7'h24 || an !== 4'b1110) begin
            miscompares++; $display("FAIL tear_wrap: got %h/%b want 24/1110", seg, an);
        end
    endtask

    task automatic test_enable;
        dp = 4'b1111;
        advance();
        // Scan edge and enable falling on the same cycle.
        scan_clk = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tick();
        vectors++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp_n !== 1'b1) begin
            miscompares++; $display("FAIL en_off: got %b/%h/%b want 1111/7f/1", an, seg, dp_n);
        end
        vectors++;
        if (digit_idx !== 2'd1) begin
            miscompares++; $display("FAIL en_hold_idx: got %0d want 1", digit_idx);
        end
        scan_clk = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (6) tick();
        vectors++;
        if (an !== 4'b1111) begin
            miscompares++; $display("FAIL en_wait_edge: got %b want 1111", an);
        end
        advance();
        vectors++;
        if (digit_idx !== 2'd0 || an !== 4'b1110 || seg !== 7'h24 || dp_n !== 1'b0) begin
            miscompares++;
            $display("FAIL en_first: got %0d/%b/%h/%b want 0/1110/24/0", digit_idx, an, seg, dp_n);
        end
    endtask

    task automatic test_reset_guard;
        scan_clk = 1'b1;
        repeat (3) tick();
        vectors++;
        if (digit_idx !== 2'd1 || an !== 4'b1111) begin
            miscompares++; $display("FAIL rg_guard: got %0d/%b want 1/1111", digit_idx, an);
        end
        reset    = 1'b1;
        scan_clk = 1'b0;
        tick();
        reset = 1'b0;
        vectors++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp_n !== 1'b1 || digit_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL rg_reset: got %b/%h/%b/%0d want 1111/7f/1/0", an, seg, dp_n, digit_idx);
        end
        repeat (4) tick();
        scan_clk = 1'b1;
        tick();
        reset    = 1'b1;
        scan_clk = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        vectors++;
        if (an !== 4'b1111 || digit_idx !== 2'd0) begin
            miscompares++; $display("FAIL rg_pending: got %b/%0d want 1111/0", an, digit_idx);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_edge_latency();
        test_lz();
        test_no_tear();
        test_enable();
        test_reset_guard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
